rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port among NREQ writeback requesters: ALU, load unit, MUL/DIV unit and CP0 move.
- Grants one requester per cycle by round-robin and drives registered write-enable, address and data to the register file.
- Keeps a per-register busy scoreboard, set when an instruction reserves a destination at issue and cleared when that register's write reaches the register file.
- Sits between the execution units and the register file in the multicycle datapath.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_wb_arbiter_rr_arbiter.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 95 +++++++++
 tb/tb_rf_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file writeback constants: geometry and fixed requester slots
// on the write-port arbiter.
package rf_pkg;
  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;
  localparam int WB_CP0    = 3;
endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter. The search starts at the rotating pointer, and the
// pointer moves one past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // advance low (flush or reset) suppresses the grant and freezes the pointer
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (advance && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_d    = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. It round-robins writebacks onto one
// registered write port and tracks outstanding destinations in a busy scoreboard.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_waddr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 flush,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [(2**AW)-1:0]   busy_mask
);
  localparam int NREG = 2**AW;

  logic [NREQ-1:0] gnt;
  logic            advance;
  logic            gnt_any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign advance = ~flush & ~reset;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  assign req_ready = gnt;
  assign gnt_any   = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_waddr[i*AW +: AW];
        sel_data = req_wdata[i*DW +: DW];
      end
    end
  end

  // A $0 destination still handshakes, but it never raises the write enable.
  always_comb begin
    we_d    = gnt_any && (sel_addr != '0);
    waddr_d = gnt_any ? sel_addr : waddr_q;
    wdata_d = gnt_any ? sel_data : wdata_q;
    busy_d  = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (we_d)      busy_d[sel_addr] = 1'b0;
      // A newer reservation of the same register outranks the retiring write.
      if (rsv_valid) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign busy_mask = busy_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed table, fairness, reset
// corner cases, and randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [19:0]  req_waddr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic         flush;
  logic         rsv_valid;
  logic [4:0]   rsv_addr;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [31:0]  busy_mask;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter #(.NREQ(4), .DW(RF_DW), .AW(RF_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .flush     (flush),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_busy [32];
  int          last_g;
  logic [3:0]  last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    int g;
    #3;
    g = -1;
    if (!flush) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    last_g     = g;
    last_ready = req_ready;
    chk("req_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      m_waddr = req_waddr[g*5 +: 5];
      m_wdata = req_wdata[g*32 +: 32];
      m_we    = (m_waddr != 0);
      m_ptr   = (g + 1) % 4;
    end else begin
      m_we = 0;
    end
    if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
    end else begin
      if (m_we) m_busy[m_waddr] = 0;
      if (rsv_valid) m_busy[rsv_addr] = 1;
      m_busy[0] = 0;
    end
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("busy_mask", busy_mask, m_busy_vec());
  endtask

  task automatic drive_uniform(input logic [3:0] v, input logic [4:0] a, input logic [31:0] d);
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_waddr[i*5 +: 5]   = 5'(a + 5'(i));
      req_wdata[i*32 +: 32] = d + 32'(i);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 4'b1111; flush = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy_mask, 0);
    reset = 1'b0;
    req_valid = '0;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        flush;
    logic        rsv;
    logic [4:0]  raddr;
    logic [3:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tab [13];

  bit          pend  [4];
  logic [4:0]  paddr [4];
  logic [31:0] pdata [4];

  initial begin
    // Requester i gets address addr+i and data data+i.
    tab[0]  = '{4'b0001, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 4'b0001, 1'b1, 5'd5,  32'h0};
    tab[1]  = '{4'b0000, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 5'd5,  32'h0};
    tab[2]  = '{4'b0000, 5'd0,  32'h0,        1'b0, 1'b1, 5'd7, 4'b0000, 1'b0, 5'd5,  32'h80};
    tab[3]  = '{4'b0100, 5'd30, 32'h1232,     1'b0, 1'b0, 5'd0, 4'b0100, 1'b0, 5'd0,  32'h80};
    tab[4]  = '{4'b1000, 5'd4,  32'h100,      1'b0, 1'b0, 5'd0, 4'b1000, 1'b1, 5'd7,  32'h0};
    tab[5]  = '{4'b0001, 5'd7,  32'h200,      1'b0, 1'b1, 5'd7, 4'b0001, 1'b1, 5'd7,  32'h80};
    tab[6]  = '{4'b0000, 5'd0,  32'h0,        1'b0, 1'b1, 5'd4, 4'b0000, 1'b0, 5'd7,  32'h90};
    tab[7]  = '{4'b0000, 5'd0,  32'h0,        1'b0, 1'b1, 5'd5, 4'b0000, 1'b0, 5'd7,  32'hB0};
    tab[8]  = '{4'b0000, 5'd0,  32'h0,        1'b0, 1'b1, 5'd6, 4'b0000, 1'b0, 5'd7,  32'hF0};
    tab[9]  = '{4'b0011, 5'd10, 32'h300,      1'b1, 1'b1, 5'd9, 4'b0000, 1'b0, 5'd7,  32'h0};
    tab[10] = '{4'b0011, 5'd10, 32'h300,      1'b0, 1'b0, 5'd0, 4'b0010, 1'b1, 5'd11, 32'h0};
    tab[11] = '{4'b0001, 5'd10, 32'h300,      1'b0, 1'b0, 5'd0, 4'b0001, 1'b1, 5'd10, 32'h0};
    tab[12] = '{4'b0000, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0, 4'b0000, 1'b0, 5'd10, 32'h0};

    req_waddr = '0; req_wdata = '0;
    do_reset();

    foreach (tab[n]) begin
      drive_uniform(tab[n].valid, tab[n].addr, tab[n].data);
      flush = tab[n].flush; rsv_valid = tab[n].rsv; rsv_addr = tab[n].raddr;
      step();
      chk($sformatf("tab%0d_ready", n), last_ready, tab[n].e_ready);
      chk($sformatf("tab%0d_we", n), rf_we, tab[n].e_we);
      chk($sformatf("tab%0d_waddr", n), rf_waddr, tab[n].e_waddr);
      chk($sformatf("tab%0d_busy", n), busy_mask, tab[n].e_busy);
    end
    flush = 1'b0; rsv_valid = 1'b0;

    // Fairness: all requesters continuously valid right after reset.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive_uniform(4'b1111, 5'd1, $urandom);
      step();
      chk("fair_grant", 64'(last_g), 64'(c % 4));
      chk("fair_we", rf_we, 1);
    end

    // Reset pulsed between edges while a write and a reservation are live.
    drive_uniform(4'b0001, 5'd12, 32'hCAFE0000);
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_valid = 1'b0;
    req_valid = 4'b1111;
    #2 reset = 1'b1;
    #1;
    chk("async_we", rf_we, 0);
    chk("async_waddr", rf_waddr, 0);
    chk("async_wdata", rf_wdata, 0);
    chk("async_busy", busy_mask, 0);
    chk("async_ready", req_ready, 0);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive_uniform(4'b1111, 5'd3, 32'h55);
    step();
    chk("post_rst_first", 64'(last_g), 64'(WB_ALU));

    // Randomized traffic; a pending requester holds its request until granted.
    for (int i = 0; i < 4; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1;
          paddr[i] = 5'($urandom_range(0, 31));
          pdata[i] = $urandom;
        end
        req_valid[i]          = pend[i];
        req_waddr[i*5 +: 5]   = paddr[i];
        req_wdata[i*32 +: 32] = pdata[i];
      end
      flush     = ($urandom_range(0, 15) == 0);
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr  = 5'($urandom_range(0, 31));
      step();
      if (last_g >= 0) pend[last_g] = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
